// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered operands, FSM-sequenced execution, N/V/Z/C flags.
// Optional BCD adjust cycle is compiled in when DECIMAL_ADJ_EN is defined.
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH    = 8,
  parameter int OP_WIDTH = 4
) (
  input  logic                phi1,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OP_WIDTH-1:0] func,
  input  logic                carry_in,
  input  logic                dec_mode,
  output logic [WIDTH-1:0]    result,
  output logic [3:0]          flags,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
`ifdef DECIMAL_ADJ_EN
    S_DECADJ = 2'd3,
`endif
    S_DONE   = 2'd2
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_SUM = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_ASL = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_LSR = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_ROL = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_ROR = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_CMP = OP_WIDTH'(9);

  state_t              state;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [OP_WIDTH-1:0] func_q;
  logic                cin_q;
  logic                accept;

  logic [WIDTH:0]      wide;
  logic [WIDTH-1:0]    bin_res;
  logic                bin_c, bin_v, bin_n, bin_z;
  logic                legal, writes_res, upd_c, upd_v;

  assign accept = start && (state == S_IDLE || state == S_DONE);

  // NOTE: operand latches carry no reset; they are only read after a capture, and leaving
  // them out of the reset path keeps reset fan-out to the control and output state.
  always_ff @(posedge phi1) begin
    if (accept) begin
      a_q    <= a;
      b_q    <= b;
      func_q <= func;
      cin_q  <= carry_in;
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    wide       = '0;
    bin_res    = '0;
    bin_c      = 1'b0;
    bin_v      = 1'b0;
    legal      = 1'b1;
    writes_res = 1'b1;
    upd_c      = 1'b0;
    upd_v      = 1'b0;
    case (func_q)
      OP_SUM: begin
        wide  = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);
        bin_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (wide[WIDTH-1] != a_q[WIDTH-1]);
        upd_c = 1'b1;
        upd_v = 1'b1;
      end
      OP_SUB: begin
        wide  = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(cin_q);
        bin_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (wide[WIDTH-1] != a_q[WIDTH-1]);
        upd_c = 1'b1;
        upd_v = 1'b1;
      end
      OP_AND: wide = {1'b0, a_q & b_q};
      OP_OR:  wide = {1'b0, a_q | b_q};
      OP_XOR: wide = {1'b0, a_q ^ b_q};
      OP_ASL: begin wide = {a_q, 1'b0};                     upd_c = 1'b1; end
      OP_LSR: begin wide = {a_q[0], 1'b0, a_q[WIDTH-1:1]};  upd_c = 1'b1; end
      OP_ROL: begin wide = {a_q, cin_q};                    upd_c = 1'b1; end
      OP_ROR: begin wide = {a_q[0], cin_q, a_q[WIDTH-1:1]}; upd_c = 1'b1; end
      OP_CMP: begin
        wide       = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        writes_res = 1'b0;
        upd_c      = 1'b1;
      end
      default: begin
        legal      = 1'b0;
        writes_res = 1'b0;
      end
    endcase
    bin_res = wide[WIDTH-1:0];
    bin_c   = wide[WIDTH];
  end

  assign bin_n = bin_res[WIDTH-1];
  assign bin_z = (bin_res == '0);

`ifdef DECIMAL_ADJ_EN
  logic             dec_q, dec_op, dec_c, dec_cy;
  logic [4:0]       dec_nib;
  logic [WIDTH-1:0] dec_res;

  always_ff @(posedge phi1) begin
    if (accept) dec_q <= dec_mode;
  end

  assign dec_op = dec_q && (func_q == OP_SUM || func_q == OP_SUB);

  // Nibble chain: SUM carries on >9, SUB borrows on underflow; cy holds borrow for SUB.
  always_comb begin
    dec_res = '0;
    dec_nib = '0;
    dec_cy  = (func_q == OP_SUB) ? ~cin_q : cin_q;
    for (int i = 0; i < WIDTH/4; i++) begin
      if (func_q == OP_SUB) begin
        dec_nib = {1'b0, a_q[4*i +: 4]} - {1'b0, b_q[4*i +: 4]} - {4'b0, dec_cy};
        dec_cy  = dec_nib[4];
        if (dec_cy) dec_nib = dec_nib - 5'd6;
      end else begin
        dec_nib = {1'b0, a_q[4*i +: 4]} + {1'b0, b_q[4*i +: 4]} + {4'b0, dec_cy};
        dec_cy  = (dec_nib > 5'd9);
        if (dec_cy) dec_nib = dec_nib + 5'd6;
      end
      dec_res[4*i +: 4] = dec_nib[3:0];
    end
    dec_c = (func_q == OP_SUB) ? ~dec_cy : dec_cy;
  end
`else
  logic unused_dec_mode;
  assign unused_dec_mode = dec_mode;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge phi1) begin
    if (reset) begin
      state   <= S_IDLE;
      result  <= '0;
      flags   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          state <= S_EXEC;
          busy  <= 1'b1;
        end
        S_EXEC: begin
`ifdef DECIMAL_ADJ_EN
          if (dec_op) state <= S_DECADJ;
          else
`endif
          begin
            if (writes_res) result <= bin_res;
            if (legal) begin
              flags[3] <= bin_n;
              flags[1] <= bin_z;
            end
            if (upd_v) flags[2] <= bin_v;
            if (upd_c) flags[0] <= bin_c;
            illegal <= ~legal;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end
        end
`ifdef DECIMAL_ADJ_EN
        S_DECADJ: begin
          // N/V/Z come from the binary intermediate, C from the decimal chain.
          result <= dec_res;
          flags  <= {bin_n, bin_v, bin_z, dec_c};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
`endif
        S_DONE: begin
          if (accept) begin
            state <= S_EXEC;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a behavioural model pushes expected result/flags per issued op,
// a negedge monitor pops and compares on every done pulse. Honours DECIMAL_ADJ_EN when defined.
`timescale 1ns/1ps
module tb_alu_seq;

  logic       phi1, reset, start, carry_in, dec_mode;
  logic [7:0] a, b, result;
  logic [3:0] func, flags;
  logic       busy, done, illegal;

  alu_seq dut (
    .phi1(phi1), .reset(reset), .start(start), .a(a), .b(b), .func(func),
    .carry_in(carry_in), .dec_mode(dec_mode), .result(result), .flags(flags),
    .busy(busy), .done(done), .illegal(illegal)
  );

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    logic       ill;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_res;
  logic [3:0] m_flags;
  int         checks = 0;
  int         errors = 0;

  function automatic int bcd2i(input logic [7:0] x);
    return int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [7:0] i2bcd(input int t);
    logic [3:0] hi, lo;
    hi = 4'(t / 10);
    lo = 4'(t % 10);
    return {hi, lo};
  endfunction

  // Model one op against the bench's own result/flag state; returns expected latency.
  task automatic expect_op(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                           input logic cin, input logic dec, input string name, output int lat);
    exp_t e;
    int ua, ub, sa, sb, ci, t, st;
    logic [7:0] r, rf;
    logic n, v, z, c, leg;
    ua = av; ub = bv; sa = $signed(av); sb = $signed(bv); ci = cin;
    r = m_res; {n, v, z, c} = m_flags; leg = 1'b1; lat = 2; t = 0;
    case (op)
      4'd0: begin t = ua + ub + ci; st = sa + sb + ci; r = t[7:0]; c = (t > 255); v = (st > 127) || (st < -128); end
      4'd1: begin t = ua - ub - (1 - ci); st = sa - sb - (1 - ci); r = t[7:0]; c = (t >= 0); v = (st > 127) || (st < -128); end
      4'd2: r = av & bv;
      4'd3: r = av | bv;
      4'd4: r = av ^ bv;
      4'd5: begin t = ua * 2; r = t[7:0]; c = (t > 255); end
      4'd6: begin c = (ua % 2) == 1; r = 8'(ua / 2); end
      4'd7: begin t = ua * 2 + ci; r = t[7:0]; c = (t > 255); end
      4'd8: begin t = ua + 256 * ci; c = (t % 2) == 1; r = 8'(t / 2); end
      4'd9: begin t = ua - ub; c = (t >= 0); end
      default: leg = 1'b0;
    endcase
    if (leg) begin
      rf = (op == 4'd9) ? t[7:0] : r;
      n  = rf[7];
      z  = (rf == 8'h00);
    end
`ifdef DECIMAL_ADJ_EN
    if (dec && op <= 4'd1) begin
      lat = 3;
      if (op == 4'd0) t = bcd2i(av) + bcd2i(bv) + ci;
      else            t = bcd2i(av) - bcd2i(bv) - (1 - ci);
      c = (op == 4'd0) ? (t > 99) : (t >= 0);
      if (t < 0) t = t + 100;
      r = i2bcd(t % 100);
    end
`else
    if (dec) lat = 2;
`endif
    e.res = r; e.flg = {n, v, z, c}; e.ill = ~leg; e.name = name;
    sb_q.push_back(e);
    m_res = r; m_flags = {n, v, z, c};
  endtask

  always @(negedge phi1) begin
    if (!reset && done) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done result=%h flags=%b", result, flags);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (result !== e.res) begin errors++; $display("FAIL %s result got=%h exp=%h", e.name, result, e.res); end
        checks++;
        if (flags !== e.flg) begin errors++; $display("FAIL %s flags got=%b exp=%b", e.name, flags, e.flg); end
        checks++;
        if (illegal !== e.ill) begin errors++; $display("FAIL %s illegal got=%b exp=%b", e.name, illegal, e.ill); end
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                       input logic cin, input logic dec);
    func = op; a = av; b = bv; carry_in = cin; dec_mode = dec;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                        input logic cin, input logic dec, input string name);
    int lat, edges;
    @(negedge phi1);
    drive(op, av, bv, cin, dec);
    start = 1'b1;
    expect_op(op, av, bv, cin, dec, name, lat);
    @(posedge phi1);
    edges = 1;
    @(negedge phi1);
    start = 1'b0;
    drive(4'd2, 8'h00, 8'h00, 1'b0, 1'b0);
    while (!done && edges < 8) begin
      @(posedge phi1);
      edges++;
      @(negedge phi1);
    end
    checks++;
    if (!done || edges != lat) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=%0d done=%b", name, edges, lat, done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; drive(4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge phi1);
    @(negedge phi1);
    checks++;
    if ({result, flags, busy, done, illegal} !== 15'h0) begin
      errors++;
      $display("FAIL reset_state result=%h flags=%b busy=%b done=%b illegal=%b", result, flags, busy, done, illegal);
    end
    reset = 1'b0;
    m_res = 8'h00; m_flags = 4'h0;
  endtask

  task automatic test_sum;
    run_op(4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, "sum_overflow");
    run_op(4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, "sum_wrap");
    run_op(4'd0, 8'h10, 8'h20, 1'b1, 1'b0, "sum_cin");
  endtask

  task automatic test_sub_cmp;
    run_op(4'd1, 8'h00, 8'h01, 1'b1, 1'b0, "sub_borrow");
    run_op(4'd9, 8'h05, 8'h05, 1'b0, 1'b0, "cmp_equal");
    run_op(4'd1, 8'h80, 8'h01, 1'b1, 1'b0, "sub_overflow");
    run_op(4'd9, 8'h03, 8'h07, 1'b1, 1'b0, "cmp_less");
  endtask

  task automatic test_logic_shift;
    run_op(4'd2, 8'hF0, 8'h3C, 1'b1, 1'b0, "and");
    run_op(4'd3, 8'h80, 8'h01, 1'b1, 1'b0, "or");
    run_op(4'd4, 8'hA5, 8'hA5, 1'b1, 1'b0, "xor_zero");
    run_op(4'd5, 8'h80, 8'h00, 1'b1, 1'b0, "asl_msb");
    run_op(4'd6, 8'h01, 8'h00, 1'b1, 1'b0, "lsr_lsb");
    run_op(4'd8, 8'h01, 8'h00, 1'b1, 1'b0, "ror_cin");
    run_op(4'd7, 8'h41, 8'h00, 1'b0, 1'b0, "rol_nocin");
  endtask

  task automatic test_illegal;
    run_op(4'd0, 8'h12, 8'h34, 1'b0, 1'b0, "pre_illegal");
    run_op(4'hF, 8'hFF, 8'hFF, 1'b1, 1'b0, "illegal_f");
    run_op(4'hA, 8'h00, 8'h00, 1'b0, 1'b0, "illegal_a");
  endtask

  task automatic test_decimal;
    run_op(4'd0, 8'h19, 8'h28, 1'b0, 1'b1, "dec_sum");
    run_op(4'd0, 8'h99, 8'h01, 1'b0, 1'b1, "dec_sum_wrap");
    run_op(4'd1, 8'h00, 8'h01, 1'b1, 1'b1, "dec_sub_borrow");
    run_op(4'd1, 8'h42, 8'h17, 1'b1, 1'b1, "dec_sub");
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge phi1);
    drive(4'd7, 8'h80, 8'h00, 1'b1, 1'b0);
    start = 1'b1;
    expect_op(4'd7, 8'h80, 8'h00, 1'b1, 1'b0, "b2b_rol", lat);
    @(posedge phi1);
    @(negedge phi1);
    drive(4'd2, 8'hFF, 8'h00, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_exec busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    @(posedge phi1);
    @(negedge phi1);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done done=%b exp=1", done);
    end
    drive(4'd6, 8'h02, 8'h00, 1'b1, 1'b0);
    expect_op(4'd6, 8'h02, 8'h00, 1'b1, 1'b0, "b2b_lsr", lat);
    @(posedge phi1);
    @(negedge phi1);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reaccept busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    @(posedge phi1);
    @(negedge phi1);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done done=%b exp=1", done);
    end
  endtask

  task automatic test_reset_mid_op;
    bit saw_done;
    @(negedge phi1);
    drive(4'd0, 8'h01, 8'h01, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge phi1);
    @(negedge phi1);
    start = 1'b0;
    reset = 1'b1;
    @(posedge phi1);
    @(negedge phi1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_op busy=%b done=%b result=%h flags=%b exp all zero", busy, done, result, flags);
    end
    reset = 1'b0;
    m_res = 8'h00; m_flags = 4'h0;
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge phi1);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_abort done pulsed=%b exp=0", saw_done);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [3:0] op;
      logic [7:0] av, bv;
      op = 4'($urandom_range(0, 11));
      av = 8'($urandom);
      bv = 8'($urandom);
      run_op(op, av, bv, 1'($urandom), 1'b0, $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  initial begin
    test_reset;
    test_sum;
    test_sub_cmp;
    test_logic_shift;
    test_illegal;
    test_back_to_back;
    test_decimal;
    test_reset_mid_op;
    test_random;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge phi1);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
